mic_ctrl: RTL and testbench
===========================

MIC_CTRL -- requirements
Module: mic_ctrl

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous, active-low: clk input 1 (rising-edge clock), rst_n input 1 (async active-low reset).
REQ-002 SHALL provide ports: run in 1 (enable fetching); imem_req out 1; imem_addr out 15; imem_ack in 1; imem_data in 16.
REQ-003 SHALL provide ports: nv in 1, zr in 1 (ALU flags); a_val in 15 (current A register).
REQ-004 SHALL provide ports: zx, nx, zy, ny, f, no out 1 each (ALU controls); sel_am out 1 (1 = ALU y from M, 0 = from A).
REQ-005 SHALL provide ports: a_we, d_we, m_we out 1; a_src_imm out 1; imm out 15; pc out 15; err out 1.

Function
REQ-006 SHALL implement FSM states IDLE, FETCH, EXEC, HALT.
REQ-007 IDLE: run=1 -> FETCH next cycle; otherwise stay in IDLE.
REQ-008 FETCH: imem_req=1 and imem_addr=pc held stable until imem_ack=1; on the ack cycle latch imem_data into the instruction register and go to EXEC.
REQ-009 imem_ack outside FETCH SHALL be ignored.
REQ-010 EXEC lasts exactly one cycle; it then goes to FETCH if run=1, else to IDLE. Minimum throughput is 2 cycles per instruction, with ack in the first FETCH cycle.
REQ-011 A-instruction (instr[15]=0), in EXEC: a_we=1, a_src_imm=1, imm=instr[14:0]; no other write enable; pc <= pc+1.
REQ-012 C-instruction, in EXEC:
  - ALU controls: zx=instr[11], nx=[10], zy=[9], ny=[8], f=[7], no=[6].
  - sel_am=instr[12].
  - Write enables: a_we=[5], d_we=[4], m_we=[3]; a_src_imm=0.
REQ-013 Jump condition: jmp = (instr[2]&nv) | (instr[1]&zr) | (instr[0]&~nv&~zr), with nv and zr sampled in the EXEC cycle.
REQ-014 C-instruction PC update: pc <= jmp ? a_val : pc+1. The jump target is a_val as seen during EXEC, before this instruction's A write takes effect.
REQ-015 pc+1 SHALL wrap 15'h7FFF -> 15'h0000.
REQ-016 Outside EXEC, all ALU controls, sel_am, a_we, d_we, m_we, a_src_imm SHALL be 0 and imm SHALL be 0.
REQ-017 run deasserted during FETCH SHALL NOT abort the handshake: the fetch and EXEC complete, then the FSM goes to IDLE.
REQ-018 pc SHALL change only at the end of EXEC.

Reset
REQ-019 On rst_n=0, immediately: state=IDLE, pc=0, instruction register=0, imem_req=0, err=0, all write enables and ALU controls 0.
REQ-020 Reset asserted mid-FETCH SHALL drop imem_req asynchronously; a pending ack after release SHALL be ignored.

Configuration
REQ-021 Macro MIC_CTRL_ILLEGAL_TRAP_EN.
  - Defined: a C-instruction with instr[14:13]!=2'b11 is illegal; its EXEC cycle asserts no write enables, sets err=1 (sticky) and goes to HALT. HALT is left only by reset.
  - Undefined: instr[14:13] is ignored, the HALT state and err logic are not built, and err is tied 0.

Structure
REQ-022 Shared package mic_pkg SHALL hold: the state enum; instruction field bit-position constants (A/C flag, a-bit, comp, dest, jump); the PC width constant (15).
REQ-023 Jump evaluation SHALL be a sub-module mic_jmp (inputs: jump bits, nv, zr; output: jmp). Decode and FSM stay in mic_ctrl.

Verification
REQ-024 A-instr: imem_data=16'h1234 with immediate ack -> EXEC shows a_we=1, a_src_imm=1, imm=15'h1234; pc goes 0->1.
REQ-025 C-instr 16'hEC10 (D=A): EXEC shows zx..no=110000, sel_am=0, d_we=1, a_we=0, m_we=0; pc+1.
REQ-026 JEQ 16'hE302 with zr=1, a_val=15'h0040 -> pc=15'h0040. Same instruction with zr=0, nv=0 -> pc+1.
REQ-027 imem_ack delayed 5 cycles -> imem_req and imem_addr stable for 6 cycles; run dropped mid-wait -> EXEC completes, then IDLE.
REQ-028 pc=15'h7FFF with a non-jump instruction -> pc=0. rst_n pulsed during FETCH -> pc=0, imem_req=0 immediately.
REQ-029 With MIC_CTRL_ILLEGAL_TRAP_EN: 16'h8000 -> err=1, no write enables, HALT until reset. Without the macro: the same instruction executes normally as a C-instruction.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared types and instruction field positions for the mic_ctrl instruction sequencer.
package mic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int PC_W = 15;

  localparam int BIT_AC  = 15;
  localparam int ILL_HI  = 14;
  localparam int ILL_LO  = 13;
  localparam int BIT_A   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_HI = 5;
  localparam int DEST_LO = 3;
  localparam int JMP_HI  = 2;
  localparam int JMP_LO  = 0;

endpackage

// File: rtl/mic_jmp.sv
// Jump decision from the C-instruction jump bits and the ALU sign/zero flags.
module mic_jmp (
  input  logic [2:0] jbits,
  input  logic       nv,
  input  logic       zr,
  output logic       jmp
);

  assign jmp = (jbits[2] & nv) | (jbits[1] & zr) | (jbits[0] & ~nv & ~zr);

endmodule

// File: rtl/mic_ctrl.sv
// Fetch/execute sequencer: fetches a 16-bit instruction, decodes A/C forms, steers the ALU and PC.
// Build option MIC_CTRL_ILLEGAL_TRAP_EN traps C-instructions with bits [14:13] != 2'b11 into HALT.
module mic_ctrl
  import mic_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  input  logic            nv,
  input  logic            zr,
  input  logic [PC_W-1:0] a_val,
  output logic            zx,
  output logic            nx,
  output logic            zy,
  output logic            ny,
  output logic            f,
  output logic            no,
  output logic            sel_am,
  output logic            a_we,
  output logic            d_we,
  output logic            m_we,
  output logic            a_src_imm,
  output logic [PC_W-1:0] imm,
  output logic [PC_W-1:0] pc,
  output logic            err
);

  state_t          state, state_nxt;
  logic [15:0]     instr;
  logic [PC_W-1:0] pc_nxt, pc_inc;
  logic            ir_load, jmp, is_c, illegal;

  assign is_c      = instr[BIT_AC];
  assign pc_inc    = pc + PC_W'(1);
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  mic_jmp u_jmp (
    .jbits (instr[JMP_HI:JMP_LO]),
    .nv    (nv),
    .zr    (zr),
    .jmp   (jmp)
  );

`ifdef MIC_CTRL_ILLEGAL_TRAP_EN
  assign illegal = is_c && (instr[ILL_HI:ILL_LO] != 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (state == EXEC && illegal)
      err <= 1'b1;
  end
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_load   = 1'b0;
    {zx, nx, zy, ny, f, no} = '0;
    sel_am    = 1'b0;
    a_we      = 1'b0;
    d_we      = 1'b0;
    m_we      = 1'b0;
    a_src_imm = 1'b0;
    imm       = '0;
    case (state)
      IDLE: if (run) state_nxt = FETCH;
      FETCH: begin
        if (imem_ack) begin
          ir_load   = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = run ? FETCH : IDLE;
        if (!is_c) begin
          a_we      = 1'b1;
          a_src_imm = 1'b1;
          imm       = instr[PC_W-1:0];
          pc_nxt    = pc_inc;
        end else if (illegal) begin
          // Trap: nothing is written and the PC stays on the offending instruction.
          state_nxt = HALT;
        end else begin
          {zx, nx, zy, ny, f, no} = instr[COMP_HI:COMP_LO];
          sel_am             = instr[BIT_A];
          {a_we, d_we, m_we} = instr[DEST_HI:DEST_LO];
          pc_nxt             = jmp ? a_val : pc_inc;
        end
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= '0;
      instr <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (ir_load) instr <= imem_data;
    end
  end

endmodule

// File: tb/tb_mic_ctrl.sv
// Directed and randomized bench for mic_ctrl against a behavioural instruction-level model.
module tb_mic_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, run, imem_ack, nv, zr;
  logic [15:0] imem_data;
  logic [14:0] a_val;
  logic        imem_req, zx, nx, zy, ny, f, no, sel_am, a_we, d_we, m_we, a_src_imm, err;
  logic [14:0] imem_addr, imm, pc;
  logic [10:0] ctrl;

  int tests = 0;
  int fails = 0;
  int mpc   = 0;

  assign ctrl = {zx, nx, zy, ny, f, no, sel_am, a_we, d_we, m_we, a_src_imm};

  always #5 clk = ~clk;

  mic_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .nv(nv), .zr(zr), .a_val(a_val),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .sel_am(sel_am),
    .a_we(a_we), .d_we(d_we), .m_we(m_we), .a_src_imm(a_src_imm),
    .imm(imm), .pc(pc), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Jump taken when the ALU result class (negative / zero / positive) is enabled.
  function automatic logic model_jmp(input logic [2:0] j, input logic n, input logic z);
    logic neg, zero, pos;
    neg  = n;
    zero = z;
    pos  = !n && !z;
    return (neg && j[2]) || (zero && j[1]) || (pos && j[0]);
  endfunction

  function automatic logic model_illegal(input logic [15:0] instr);
`ifdef MIC_CTRL_ILLEGAL_TRAP_EN
    return instr[15] && (instr[14:13] != 2'b11);
`else
    return 1'b0;
`endif
  endfunction

  task automatic start_fetch();
    run = 1'b1;
    @(posedge clk); #1;
  endtask

  // Enters with the DUT in FETCH just after a rising edge; leaves just after the EXEC edge.
  task automatic exec_instr(input logic [15:0] instr, input int delay, input logic nvv,
                            input logic zrv, input logic [14:0] av, input int drop_at);
    logic        is_a, ill, run_at_exec;
    logic [10:0] exp_ctrl;
    is_a = !instr[15];
    ill  = model_illegal(instr);
    for (int k = 0; k <= delay; k++) begin
      if (k == drop_at) run = 1'b0;
      imem_ack  = (k == delay);
      imem_data = (k == delay) ? instr : 16'($urandom);
      @(negedge clk);
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, mpc);
      if (k == 0) chk("fetch_outputs_zero", {ctrl, imm}, 0);
      @(posedge clk); #1;
    end
    imem_ack  = 1'($urandom);
    imem_data = 16'($urandom);
    nv = nvv; zr = zrv; a_val = av;
    @(negedge clk);
    chk("exec_req_low", imem_req, 0);
    chk("exec_pc_hold", pc, mpc);
    if (ill) begin
      chk("illegal_no_we", {a_we, d_we, m_we}, 0);
    end else if (is_a) begin
      exp_ctrl = 11'b000000_0_1_0_0_1;
      chk("a_ctrl", ctrl, exp_ctrl);
      chk("a_imm", imm, instr[14:0]);
    end else begin
      exp_ctrl = {instr[11:6], instr[12], instr[5], instr[4], instr[3], 1'b0};
      chk("c_ctrl", ctrl, exp_ctrl);
    end
    run_at_exec = run;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    if (ill) begin
      chk("trap_err", err, 1);
      chk("trap_req", imem_req, 0);
    end else begin
      if (is_a || !model_jmp(instr[2:0], nvv, zrv)) mpc = (mpc + 1) % 32768;
      else mpc = av;
      chk("err_clear", err, 0);
      chk("next_req", imem_req, run_at_exec);
    end
    chk("pc_after", pc, mpc);
  endtask

  initial begin
    logic [15:0] ri;
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_data = '0;
    nv = 1'b0; zr = 1'b0; a_val = '0;
    #7;
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_err", err, 0);
    chk("rst_outputs", {ctrl, imm}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_no_run", imem_req, 0);
    @(posedge clk); #1;
    start_fetch();

    exec_instr(16'h1234, 0, 1'b0, 1'b0, 15'h0000, -1);
    exec_instr(16'hEC10, 0, 1'b0, 1'b0, 15'h0000, -1);
    exec_instr(16'hE302, 0, 1'b0, 1'b1, 15'h0040, -1);
    chk("jeq_taken_pc", pc, 15'h0040);
    exec_instr(16'hE302, 1, 1'b0, 1'b0, 15'h0123, -1);
    chk("jeq_not_taken_pc", pc, 15'h0041);

    exec_instr(16'hEC10, 5, 1'b0, 1'b0, 15'h0000, 2);
    @(negedge clk);
    chk("idle_after_drop", imem_req, 0);
    @(posedge clk); #1;
    start_fetch();

    exec_instr(16'hE007, 0, 1'b1, 1'b0, 15'h7FFF, -1);
    exec_instr(16'hEC10, 2, 1'b0, 1'b0, 15'h1000, -1);
    chk("pc_wrap", pc, 0);

    for (int i = 0; i < 40; i++) begin
      ri = 16'($urandom);
`ifdef MIC_CTRL_ILLEGAL_TRAP_EN
      if (ri[15]) ri[14:13] = 2'b11;
`endif
      exec_instr(ri, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                 15'($urandom), -1);
    end

    exec_instr(16'h8000, 0, 1'b0, 1'b0, 15'h2222, -1);
`ifdef MIC_CTRL_ILLEGAL_TRAP_EN
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_req", imem_req, 0);
      chk("halt_err", err, 1);
      chk("halt_pc", pc, mpc);
    end
    imem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("halt_rst_err", err, 0);
    mpc = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exec_instr(16'h0777, 0, 1'b0, 1'b0, 15'h0000, -1);
`endif

    imem_ack = 1'b0;
    @(negedge clk);
    chk("pre_rst_fetch", imem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", imem_req, 0);
    chk("async_rst_pc", pc, 0);
    mpc = 0;
    run = 1'b0;
    imem_ack = 1'b1;
    imem_data = 16'hEC10;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ack_after_rst_ignored_req", imem_req, 0);
    chk("ack_after_rst_ignored_pc", pc, 0);
    imem_ack = 1'b0;
    @(posedge clk); #1;
    start_fetch();
    exec_instr(16'h0005, 0, 1'b0, 1'b0, 15'h0000, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
